// File: rtl/data_bus_responder.sv
// data_bus_responder: same-cycle data-port responder with word RAM, GPIO and compare/auto-reload timer
module data_bus_responder #(
  parameter int          MEM_WORDS = 256,
  parameter logic [31:0] MMIO_BASE = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        WE,
  input  logic [31:0] address_to_mem,
  input  logic [31:0] data_to_mem,
  output logic [31:0] data_from_mem,
  output logic [31:0] gpio_out,
  output logic        timer_irq
);
  localparam int AW = $clog2(MEM_WORDS);
  logic [31:0] mem [MEM_WORDS];
  logic [31:0] gpio_q, gpio_d, count_q, count_d, cmp_q, cmp_d, mmio_rd;
  logic en_q, en_d, irq_en_q, irq_en_d, match_q, match_d, err_q, err_d, irq_q, irq_d;
  logic aligned, ram_hit, mmio_hit, ram_we, hit;
  logic [3:0] reg_we;
  logic [AW-1:0] idx;
  always_comb begin
    aligned = address_to_mem[1:0] == 2'b00;
    ram_hit = address_to_mem < 32'(4 * MEM_WORDS);
    mmio_hit = address_to_mem[31:4] == MMIO_BASE[31:4];
    idx = address_to_mem[2 +: AW];
    ram_we = WE && aligned && ram_hit;
    reg_we = (WE && aligned && mmio_hit) ? (4'b0001 << address_to_mem[3:2]) : 4'b0000;
    mmio_rd = address_to_mem[3] ? (address_to_mem[2] ? {28'b0, err_q, match_q, irq_en_q, en_q} : cmp_q)
                                : (address_to_mem[2] ? count_q : gpio_q);
    data_from_mem = !aligned ? '0 : ram_hit ? mem[idx] : mmio_hit ? mmio_rd : '0;
    hit = en_q && count_q == cmp_q;
    gpio_d = reg_we[0] ? data_to_mem : gpio_q;
    count_d = reg_we[1] ? data_to_mem : !en_q ? count_q : hit ? '0 : count_q + 32'd1;
    cmp_d = reg_we[2] ? data_to_mem : cmp_q;
    en_d = reg_we[3] ? data_to_mem[0] : en_q;
    irq_en_d = reg_we[3] ? data_to_mem[1] : irq_en_q;
    match_d = hit || (match_q && !(reg_we[3] && data_to_mem[2]));
    err_d = (WE && !(aligned && (ram_hit || mmio_hit))) || (err_q && !(reg_we[3] && data_to_mem[3]));
    irq_d = match_q && irq_en_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      gpio_q <= '0;
      count_q <= '0;
      cmp_q <= '1;
      en_q <= 1'b0;
      irq_en_q <= 1'b0;
      match_q <= 1'b0;
      err_q <= 1'b0;
      irq_q <= 1'b0;
    end else begin
      gpio_q <= gpio_d;
      count_q <= count_d;
      cmp_q <= cmp_d;
      en_q <= en_d;
      irq_en_q <= irq_en_d;
      match_q <= match_d;
      err_q <= err_d;
      irq_q <= irq_d;
    end
  end
  always_ff @(posedge clk) if (ram_we) mem[idx] <= data_to_mem;
  assign gpio_out = gpio_q;
  assign timer_irq = irq_q;
endmodule

// File: tb/tb_data_bus_responder.sv
// tb_data_bus_responder: scoreboard bench with a behavioural model of the data-port responder
module tb_data_bus_responder;
  localparam logic [31:0] BASE = 32'h8000_0000;
  localparam logic [31:0] A_GPIO = BASE, A_CNT = BASE + 4, A_CMP = BASE + 8, A_CTRL = BASE + 12;
  logic clk = 1'b0, reset = 1'b1, WE = 1'b0;
  logic [31:0] address_to_mem = '0, data_to_mem = '0, data_from_mem, gpio_out;
  logic timer_irq;
  always #5 clk = ~clk;
  data_bus_responder dut (
    .clk(clk), .reset(reset), .WE(WE), .address_to_mem(address_to_mem),
    .data_to_mem(data_to_mem), .data_from_mem(data_from_mem), .gpio_out(gpio_out), .timer_irq(timer_irq)
  );
  typedef struct {string nm; logic [31:0] rd; logic [31:0] gp; logic irq;} exp_t;
  exp_t sb[$];
  exp_t e;
  int n_cmp = 0, n_bad = 0;
  logic [31:0] m_ram [256];
  logic [31:0] m_gpio, m_count, m_cmp;
  logic m_en, m_ie, m_match, m_err, m_irq;
  task automatic m_reset();
    m_gpio = '0; m_count = '0; m_cmp = '1;
    m_en = 0; m_ie = 0; m_match = 0; m_err = 0; m_irq = 0;
  endtask
  function automatic logic [31:0] m_read(input logic [31:0] a);
    if (a % 4 != 0) return '0;
    if (a < 1024) return m_ram[a / 4];
    if (a >= BASE && a - BASE < 16)
      case ((a - BASE) / 4)
        0: return m_gpio;
        1: return m_count;
        2: return m_cmp;
        default: return {28'b0, m_err, m_match, m_ie, m_en};
      endcase
    return '0;
  endfunction
  task automatic step(input string nm, input logic w, input logic [31:0] a, input logic [31:0] d, input logic r = 1'b0);
    exp_t x;
    logic hit, mapped, clr;
    reset = r; WE = w; address_to_mem = a; data_to_mem = d;
    x.nm = nm; x.rd = m_read(a); x.gp = m_gpio; x.irq = m_irq;
    sb.push_back(x);
    if (r) m_reset();
    else begin
      mapped = a < 1024 || (a >= BASE && a - BASE < 16);
      hit = m_en && m_count == m_cmp;
      clr = w && a == A_CTRL;
      m_irq = m_match && m_ie;
      m_match = hit || (m_match && !(clr && d[2]));
      m_err = (w && (a % 4 != 0 || !mapped)) || (m_err && !(clr && d[3]));
      if (m_en) m_count = hit ? 32'd0 : m_count + 32'd1;
      if (w && a % 4 == 0) begin
        if (a < 1024) m_ram[a / 4] = d;
        else if (a == A_GPIO) m_gpio = d;
        else if (a == A_CNT) m_count = d;
        else if (a == A_CMP) m_cmp = d;
        else if (a == A_CTRL) begin m_en = d[0]; m_ie = d[1]; end
      end
    end
    @(posedge clk); #1;
  endtask
  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 5))
      0, 1: return 32'($urandom_range(0, 15)) * 4;
      2: return 32'($urandom_range(0, 63));
      3, 4: return BASE + 32'($urandom_range(0, 3)) * 4;
      default:
        case ($urandom_range(0, 3))
          0: return 32'h4000_0000;
          1: return 32'h0000_0400;
          2: return BASE + 16;
          default: return BASE + 1;
        endcase
    endcase
  endfunction
  always @(negedge clk) if (sb.size() > 0) begin
    e = sb.pop_front();
    if (!$isunknown(e.rd)) begin
      n_cmp++;
      if (data_from_mem !== e.rd) begin n_bad++; $display("FAIL %s data_from_mem got %h want %h", e.nm, data_from_mem, e.rd); end
    end
    n_cmp++;
    if (gpio_out !== e.gp) begin n_bad++; $display("FAIL %s gpio_out got %h want %h", e.nm, gpio_out, e.gp); end
    n_cmp++;
    if (timer_irq !== e.irq) begin n_bad++; $display("FAIL %s timer_irq got %b want %b", e.nm, timer_irq, e.irq); end
  end
  initial begin
    @(posedge clk); #1;
    m_reset();
    step("rst_ctrl", 0, A_CTRL, 0);
    step("rst_cmp", 0, A_CMP, 0);
    step("rst_cnt", 0, A_CNT, 0);
    step("rst_gpio", 0, A_GPIO, 0);
    for (int i = 0; i < 16; i++) step("ram_init", 1, 32'(i) * 4, $urandom);
    step("ram_wr", 1, 32'h10, 32'hDEAD_BEEF);
    step("ram_rd10", 0, 32'h10, 0);
    step("ram_rd14", 0, 32'h14, 0);
    step("ram_err0", 0, A_CTRL, 0);
    step("gpio_wr", 1, A_GPIO, 32'hA5);
    step("gpio_rd", 0, A_GPIO, 0);
    step("gpio_rst", 0, A_GPIO, 0, 1);
    step("gpio_after", 0, A_GPIO, 0);
    step("tm_cmp", 1, A_CMP, 3);
    step("tm_ctrl", 1, A_CTRL, 3);
    for (int i = 0; i < 10; i++) step("tm_cnt", 0, A_CNT, 0);
    step("tm_flag", 0, A_CTRL, 0);
    step("tm_w1c", 1, A_CTRL, 32'h7);
    for (int i = 0; i < 6; i++) step("tm_after", 0, A_CTRL, 0);
    step("ov_dis", 1, A_CTRL, 0);
    step("ov_cmp", 1, A_CMP, 10);
    step("ov_cnt5", 1, A_CNT, 5);
    step("ov_en", 1, A_CTRL, 32'h3);
    step("ov_cnt8", 1, A_CNT, 8);
    step("ov_rd8", 0, A_CNT, 0);
    step("ov_rd9", 0, A_CNT, 0);
    step("ov_w1c_hit", 1, A_CTRL, 32'h7);
    step("ov_flag", 0, A_CTRL, 0);
    step("er_mis", 1, 32'h2, 32'h1234_5678);
    step("er_flag1", 0, A_CTRL, 0);
    step("er_ram0", 0, 32'h0, 0);
    step("er_clr", 1, A_CTRL, 32'h8);
    step("er_unm", 1, 32'h4000_0000, 32'h55);
    step("er_unm_rd", 0, 32'h4000_0000, 0);
    step("er_flag2", 0, A_CTRL, 0);
    step("er_ld3", 0, 32'h3, 0);
    step("er_clr2", 1, A_CTRL, 32'h8);
    step("er_ld3b", 0, 32'h3, 0);
    step("er_flag0", 0, A_CTRL, 0);
    step("rm_cmp", 1, A_CMP, 100);
    step("rm_cnt", 1, A_CNT, 0);
    step("rm_en", 1, A_CTRL, 32'h3);
    for (int i = 0; i < 50; i++) step("rm_run", 0, A_CNT, 0);
    step("rm_err", 1, 32'h1, 0);
    step("rm_reset", 0, A_CNT, 0, 1);
    step("rm_cnt0", 0, A_CNT, 0);
    step("rm_ctrl0", 0, A_CTRL, 0);
    step("rm_cmp1s", 0, A_CMP, 0);
    step("rm_ram", 0, 32'h10, 0);
    for (int i = 0; i < 1500; i++) begin
      logic [31:0] a;
      a = rand_addr();
      step("rand", 1'($urandom_range(0, 1)), a, $urandom_range(0, 1) ? $urandom : 32'($urandom_range(0, 7)),
           $urandom_range(0, 299) == 0);
    end
    @(negedge clk);
    if (sb.size() != 0) begin n_bad++; $display("FAIL drain pending got %0d want 0", sb.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
